// File: rtl/uart_pkg.sv
// Shared types and helpers for the uart_byte_tx serial transmit stage.
package uart_pkg;

  localparam int DATA_W = 8;

  // Frame phases of the transmitter; PARITY is only reachable when parity is built in.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Ceiling log2 with a floor of 1 bit, used to size the baud counter.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  output logic tc
);

  localparam int             CNT_W = clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count;

  // Terminal count marks the final cycle of the current serial bit.
  assign tc = (count == LAST);

  // Free-running bit-period counter, held at zero while cleared.
  always_ff @(posedge clk) begin
    if (!rstn || clear) begin
      count <= '0;
    end else if (tc) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_byte_tx.sv
// Serial byte transmitter fed by the width-converting FIFO over a valid/enable handshake.
// Frame: start bit, 8 data bits LSB first, optional parity, STOP_BITS stop bits.
// Define UART_BYTE_TX_PARITY_EN to insert a parity bit (sense set by PARITY_ODD).
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int STOP_BITS    = 1
`ifdef UART_BYTE_TX_PARITY_EN
  ,
  parameter int PARITY_ODD   = 0
`endif
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              input_valid,
  output logic              input_enable,
  input  logic [DATA_W-1:0] data_in,
  output logic              tx,
  output logic              busy
);

  localparam logic [2:0] LAST_BIT  = 3'd7;
  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

  state_t            state;
  logic [2:0]        bit_cnt;
  logic [DATA_W-1:0] shift;
  logic              accept;
  logic              bit_end;
`ifdef UART_BYTE_TX_PARITY_EN
  localparam logic   ODD = 1'(PARITY_ODD);
  logic              parity_bit;
`endif

  assign input_enable = (state == IDLE) && rstn;
  assign accept       = input_valid && input_enable;

  // Counter is parked at zero in IDLE so every frame starts on a fresh bit period.
  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rstn (rstn),
    .clear(state == IDLE),
    .tc   (bit_end)
  );

  // Frame sequencer; tx and busy are registered together with the state.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= IDLE;
      tx      <= 1'b1;
      busy    <= 1'b0;
      bit_cnt <= '0;
      shift   <= '0;
`ifdef UART_BYTE_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (accept) begin
            shift <= data_in;
            state <= START;
            tx    <= 1'b0;
            busy  <= 1'b1;
`ifdef UART_BYTE_TX_PARITY_EN
            parity_bit <= (^data_in) ^ ODD;
`endif
          end
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            bit_cnt <= '0;
            tx      <= shift[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
`ifdef UART_BYTE_TX_PARITY_EN
              state   <= PARITY;
              tx      <= parity_bit;
`else
              state   <= STOP;
              tx      <= 1'b1;
`endif
            end else begin
              shift   <= shift >> 1;
              tx      <= shift[1];
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end
`ifdef UART_BYTE_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            state   <= STOP;
            tx      <= 1'b1;
            bit_cnt <= '0;
          end
        end
`endif
        STOP: begin
          tx <= 1'b1;
          if (bit_end) begin
            if (bit_cnt == STOP_LAST) begin
              state   <= IDLE;
              busy    <= 1'b0;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          tx      <= 1'b1;
          busy    <= 1'b0;
          bit_cnt <= '0;
        end
      endcase
    end
  end

endmodule
